// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-conflict detection and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy release to the read ports.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int IDX_W = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWR-1:0]        wb_en,
  input  logic [NWR*IDX_W-1:0]  wb_idx,
  input  logic [NWR*XLEN-1:0]   wb_data,
  input  logic [NRD*IDX_W-1:0]  rd_idx,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  alloc_en,
  input  logic [IDX_W-1:0]      alloc_idx,
  output logic                  wr_conflict
);

  logic [XLEN-1:0] regs   [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] wr_hit;
  logic [XLEN-1:0] wr_val [NREG];
  logic            conflict_d;

  // Ports are scanned in ascending order so the highest-numbered port overwrites earlier ones.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    for (int r = 0; r < NREG; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
    end
    for (int k = 0; k < NWR; k++) begin
      if (wb_en[k] && (wb_idx[k*IDX_W +: IDX_W] != '0)) begin
        wr_hit[wb_idx[k*IDX_W +: IDX_W]] = 1'b1;
        wr_val[wb_idx[k*IDX_W +: IDX_W]] = wb_data[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int k = 0; k < NWR; k++) begin
      for (int m = k + 1; m < NWR; m++) begin
        if (wb_en[k] && wb_en[m] &&
            (wb_idx[k*IDX_W +: IDX_W] == wb_idx[m*IDX_W +: IDX_W]) &&
            (wb_idx[k*IDX_W +: IDX_W] != '0)) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Register 0 is cleared by reset and never written, so it reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset because an asynchronous clear of all registers is architectural.
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (wr_hit[r]) regs[r] <= wr_val[r];
      end
    end
  end

  // A same-cycle allocation beats the write-back release: the new producer owns the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (alloc_en && (alloc_idx == IDX_W'(r))) busy[r] <= 1'b1;
        else if (wr_hit[r])                       busy[r] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_conflict <= 1'b0;
    else        wr_conflict <= conflict_d;
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [IDX_W-1:0] sel;
    assign sel = rd_idx[j*IDX_W +: IDX_W];
`ifdef REGFILE_BYPASS_EN
    assign rd_data[j*XLEN +: XLEN] = wr_hit[sel] ? wr_val[sel] : regs[sel];
    assign rd_busy[j] = wr_hit[sel] ? (alloc_en && (alloc_idx == sel)) : busy[sel];
`else
    assign rd_data[j*XLEN +: XLEN] = regs[sel];
    assign rd_busy[j] = busy[sel];
`endif
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read RISC-V register file.
- Adds configurable read/write port counts, asynchronous clear, write-port conflict resolution and a per-register busy scoreboard for the issue stage.
- Sits between decode/issue (reads, allocate) and write-back (writes, release).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers (power of two, >= 2).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- IDX_W, $clog2(NREG), register index width (derived).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wb_en  input  NWR  per-port write enable.
- wb_idx  input  NWR*IDX_W  write indices; port k occupies bits [k*IDX_W +: IDX_W].
- wb_data  input  NWR*XLEN  write data; port k occupies bits [k*XLEN +: XLEN].
- rd_idx  input  NRD*IDX_W  read indices, packed the same way.
- rd_data  output  NRD*XLEN  read data, combinational.
- rd_busy  output  NRD  scoreboard busy bit of each read index, combinational.
- alloc_en  input  1  issue marks a destination as pending.
- alloc_idx  input  IDX_W  destination index being allocated.
- wr_conflict  output  1  registered pulse: two or more enabled write ports targeted the same non-zero index in the previous cycle.

Behaviour:
- Reset:
  - rst_n low clears all registers, all busy bits and wr_conflict to 0 immediately, without waiting for a clock edge.
  - Release is synchronous to the next rising edge of clk.
  - If reset is asserted mid-operation, in-flight writes and allocations that cycle are discarded.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and allocations to index 0 are ignored.
- Write:
  - Register idx takes wb_data of port k at the rising edge when wb_en[k]=1 and wb_idx[k]=idx!=0.
  - Write latency: visible on rd_data the cycle after the edge, or the same cycle when the bypass feature is enabled.
- Write conflict:
  - If several enabled ports target the same non-zero index, the highest-numbered port wins.
  - wr_conflict=1 for exactly the following cycle; otherwise 0.
- Read: rd_data[j] = regs[rd_idx[j]], combinational, for every port independently. All ports may read the same index.
- Scoreboard:
  - busy[idx] is set at the edge where alloc_en=1 and alloc_idx=idx!=0.
  - busy[idx] is cleared at the edge where any enabled write port targets idx.
  - Simultaneous allocate and write to the same idx: busy remains 1, since the new producer wins. The data is still written.
  - Allocating an already-busy register keeps it busy. No error is raised.
  - rd_busy[j] = busy[rd_idx[j]], with the bypass rule below applied.
- No hold/else paths are required; unselected registers retain their value.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - When an enabled write port targets rd_idx[j]!=0 in the current cycle, rd_data[j] returns that write's data, using the highest-numbered winning port.
  - rd_busy[j] is forced to 0 for that index unless alloc_en targets the same index in the same cycle.
  - Read-after-write latency is 0 cycles.
- Undefined: rd_data and rd_busy reflect only stored state. Read-after-write latency is 1 cycle.

Test Plan:
- Reset/zero: pulse rst_n low mid-run after writing x5=0xDEADBEEF -> rd_data for idx 5 reads 0 with no clock edge; write port0 idx 0 data 0x1234 -> idx 0 reads 0.
- Dual write: port0 idx3=0x11, port1 idx7=0x22 in one cycle -> next cycle read ports return 0x11 and 0x22; wr_conflict=0.
- Conflict: port0 and port1 both idx9, data 0xAAAA and 0x5555 -> idx9 reads 0x5555; wr_conflict=1 for one cycle, then 0.
- Scoreboard: alloc idx4 -> rd_busy=1 next cycle; write idx4=0x77 -> busy clears after the edge; alloc and write idx4 in the same cycle -> busy stays 1 and data is 0x77.
- Bypass (REGFILE_BYPASS_EN defined): write idx12=0xCAFE while reading idx12 -> rd_data=0xCAFE and rd_busy=0 in the same cycle. Without the macro: old value in that cycle, 0xCAFE the next cycle.
- Parameter sweep: NRD=4, NWR=3, NREG=16, XLEN=64 -> random write/read/alloc traffic matches the reference model, including highest-port-wins conflicts.
